// File: rtl/matrix_pie_encoder.sv
// ----------------------------------------------------------------------------
// matrix_pie_encoder
// Transmit-side Pulse-Interval-Encoding stage for the Gen2 reader-to-tag link.
// It pulls bits from the upstream tx shift register one at a time and drives
// the modulator with: delimiter, data-0, RTcal, optional TRcal, data symbols,
// and a CW tail. All phase lengths are in Clk cycles and come from register-
// file inputs.
//
// Ports
//   Clk, Reset              clock, asynchronous active-high reset
//   tx_StartPIE             frame-active level; rising edge starts a frame
//   tx_LoadPIE              pulse; tx_ShiftOut valid from the next cycle
//   tx_ShiftOut             current bit at the shifter MSB
//   tx_PIEPreamble          sampled at frame start; 1 adds TRcal
//   r_Delim..r_PW           phase lengths (CW bits)
//   tx_ShiftNextBitToPIE    pulse; bit consumed, advance the shifter
//   tx_PIEOut               1 = carrier, 0 = attenuated
//   tx_PIEBusy              high whenever not IDLE
//   tx_PIEDone              pulse in the last tail cycle
//   tx_PIEUnderrun          pulse when a bit was not ready at a symbol boundary
// ----------------------------------------------------------------------------
module matrix_pie_encoder #(
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          tx_StartPIE,
    input  logic          tx_LoadPIE,
    input  logic          tx_ShiftOut,
    input  logic          tx_PIEPreamble,
    input  logic [CW-1:0] r_Delim,
    input  logic [CW-1:0] r_Tari,
    input  logic [CW-1:0] r_Data1Len,
    input  logic [CW-1:0] r_RTcal,
    input  logic [CW-1:0] r_TRcal,
    input  logic [CW-1:0] r_PW,
    output logic          tx_ShiftNextBitToPIE,
    output logic          tx_PIEOut,
    output logic          tx_PIEBusy,
    output logic          tx_PIEDone,
    output logic          tx_PIEUnderrun
);

    typedef enum logic [3:0] {
        S_IDLE, S_DELIM, S_D0_HI, S_D0_LO, S_RT_HI, S_RT_LO,
        S_TR_HI, S_TR_LO, S_DAT_HI, S_DAT_LO, S_HOLD, S_TAIL
    } state_t;

    state_t        r_State, w_StateNxt;
    logic [CW-1:0] r_Cnt, w_CntNxt;
    logic          r_Pending;
    logic          r_Pre;
    logic          r_StartQ;
    logic          r_PIEOut, r_Busy, r_Done, r_Underrun;

    logic          w_Rise, w_PhaseEnd, w_Abort, w_Boundary, w_Consume;
    logic          w_UnderNxt, w_PIEOutNxt, w_BusyNxt, w_DoneNxt;
    logic [CW-1:0] w_DataLen;

    // A programmed length of 0 still occupies one cycle.
    function automatic logic [CW-1:0] f_len(input logic [CW-1:0] n);
        return (n == '0) ? CW'(1) : n;
    endfunction

    // High part of a symbol: total minus the low pulse, at least one cycle.
    function automatic logic [CW-1:0] f_hi(input logic [CW-1:0] x, input logic [CW-1:0] pw);
        return (x > pw) ? (x - pw) : CW'(1);
    endfunction

    assign w_Rise     = tx_StartPIE & ~r_StartQ;
    assign w_PhaseEnd = (r_Cnt == CW'(1));
    // Dropping the frame level during the header abandons the frame.
    assign w_Abort    = ~tx_StartPIE &&
                        (r_State inside {S_DELIM, S_D0_HI, S_D0_LO, S_RT_HI,
                                         S_RT_LO, S_TR_HI, S_TR_LO});
    assign w_Boundary = w_PhaseEnd &&
                        ((r_State == S_DAT_LO) || (r_State == S_TR_LO) ||
                         ((r_State == S_RT_LO) && !r_Pre));
    assign w_Consume  = !w_Abort && r_Pending &&
                        (w_Boundary || (r_State == S_HOLD));
    assign w_DataLen  = f_hi(tx_ShiftOut ? r_Data1Len : r_Tari, r_PW);

    // The consume strobe is decoded in the same cycle as the symbol boundary
    // so the shifter advances during the last low cycle.
    assign tx_ShiftNextBitToPIE = w_Consume;
    assign tx_PIEOut            = r_PIEOut;
    assign tx_PIEBusy           = r_Busy;
    assign tx_PIEDone           = r_Done;
    assign tx_PIEUnderrun       = r_Underrun;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_State    <= S_IDLE;
            r_Cnt      <= '0;
            r_Pending  <= 1'b0;
            r_Pre      <= 1'b0;
            r_StartQ   <= 1'b0;
            r_PIEOut   <= 1'b1;
            r_Busy     <= 1'b0;
            r_Done     <= 1'b0;
            r_Underrun <= 1'b0;
        end else begin
            r_State    <= w_StateNxt;
            r_Cnt      <= w_CntNxt;
            r_StartQ   <= tx_StartPIE;
            // A new load in the consume cycle keeps the flag set.
            if (tx_LoadPIE)
                r_Pending <= 1'b1;
            else if (w_Consume)
                r_Pending <= 1'b0;
            if (r_State == S_IDLE && w_Rise)
                r_Pre <= tx_PIEPreamble;
            r_PIEOut   <= w_PIEOutNxt;
            r_Busy     <= w_BusyNxt;
            r_Done     <= w_DoneNxt;
            r_Underrun <= w_UnderNxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_StateNxt = r_State;
        w_CntNxt   = r_Cnt;
        w_UnderNxt = 1'b0;
        if (w_Abort) begin
            w_StateNxt = S_IDLE;
            w_CntNxt   = '0;
        end else if (w_Consume) begin
            w_StateNxt = S_DAT_HI;
            w_CntNxt   = w_DataLen;
        end else begin
            case (r_State)
                S_IDLE: begin
                    if (w_Rise) begin
                        w_StateNxt = S_DELIM;
                        w_CntNxt   = f_len(r_Delim);
                    end
                end
                S_HOLD: begin
                    if (!tx_StartPIE) begin
                        w_StateNxt = S_TAIL;
                        w_CntNxt   = f_len(r_PW);
                    end
                end
                default: begin
                    if (!w_PhaseEnd) begin
                        w_CntNxt = r_Cnt - CW'(1);
                    end else if (w_Boundary) begin
                        // No bit ready: stall in carrier while the frame is
                        // still active, otherwise close the frame.
                        if (tx_StartPIE) begin
                            w_StateNxt = S_HOLD;
                            w_CntNxt   = '0;
                            w_UnderNxt = 1'b1;
                        end else begin
                            w_StateNxt = S_TAIL;
                            w_CntNxt   = f_len(r_PW);
                        end
                    end else begin
                        case (r_State)
                            S_DELIM:  begin w_StateNxt = S_D0_HI;  w_CntNxt = f_hi(r_Tari, r_PW);  end
                            S_D0_HI:  begin w_StateNxt = S_D0_LO;  w_CntNxt = f_len(r_PW);         end
                            S_D0_LO:  begin w_StateNxt = S_RT_HI;  w_CntNxt = f_hi(r_RTcal, r_PW); end
                            S_RT_HI:  begin w_StateNxt = S_RT_LO;  w_CntNxt = f_len(r_PW);         end
                            S_RT_LO:  begin w_StateNxt = S_TR_HI;  w_CntNxt = f_hi(r_TRcal, r_PW); end
                            S_TR_HI:  begin w_StateNxt = S_TR_LO;  w_CntNxt = f_len(r_PW);         end
                            S_DAT_HI: begin w_StateNxt = S_DAT_LO; w_CntNxt = f_len(r_PW);         end
                            default:  begin w_StateNxt = S_IDLE;   w_CntNxt = '0;                  end
                        endcase
                    end
                end
            endcase
        end
    end

    // Output logic: registered outputs follow the state being entered.
    always_comb begin
        w_PIEOutNxt = !(w_StateNxt inside {S_DELIM, S_D0_LO, S_RT_LO, S_TR_LO, S_DAT_LO});
        w_BusyNxt   = (w_StateNxt != S_IDLE);
        w_DoneNxt   = (w_StateNxt == S_TAIL) && (w_CntNxt == CW'(1));
    end

endmodule
